game_speed_ctrl: RTL

Speed scheduler for the car game. Sequences the game through idle, running, paused and game-over phases, and emits a single one-cycle move tick whose period starts at half a second and halves automatically as the player survives longer. It replaces switch-selected speed enables with one self-progressing tick that feeds the car/obstacle movement logic.

---
 rtl/game_speed_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/game_speed_ctrl.sv
// Speed scheduler for the car game: sequences idle/run/pause/over phases and
// emits a one-cycle move tick whose period halves as the player advances levels.
module game_speed_ctrl #(
    parameter int HALF_CNT    = 25000000,
    parameter int LEVEL_TICKS = 16
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Crash,
    output logic       SpeedTick,
    output logic [1:0] Level,
    output logic       Running,
    output logic       GameOver
);

    localparam int CW = $clog2(HALF_CNT);
    localparam int LW = $clog2(LEVEL_TICKS) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;
    localparam logic [1:0] OVER   = 2'd3;

    localparam logic [CW-1:0] TERM0   = CW'(HALF_CNT - 1);
    localparam logic [CW-1:0] TERM1   = CW'(HALF_CNT / 2 - 1);
    localparam logic [CW-1:0] TERM2   = CW'(HALF_CNT / 4 - 1);
    localparam logic [LW-1:0] LT_LAST = LW'(LEVEL_TICKS - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] term;
    logic [LW-1:0] lt;

    // Terminal count for the current level: period HALF_CNT >> Level, minus one
    always_comb begin
        term = TERM2;
        case (Level)
            2'd0:    term = TERM0;
            2'd1:    term = TERM1;
            default: term = TERM2;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            lt        <= '0;
            Level     <= 2'd0;
            SpeedTick <= 1'b0;
        end else begin
            SpeedTick <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    lt    <= '0;
                    Level <= 2'd0;
                    if (Start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (Crash) begin
                        state <= OVER;
                        cnt   <= '0;
                    end else if (Pause) begin
                        state <= PAUSED;
                    end else if (cnt == term) begin
                        // The new period takes effect from this same counter restart
                        cnt       <= '0;
                        SpeedTick <= 1'b1;
                        if (Level < 2'd2) begin
                            if (lt == LT_LAST) begin
                                Level <= Level + 2'd1;
                                lt    <= '0;
                            end else begin
                                lt <= lt + LW'(1);
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PAUSED: begin
                    if (Crash) begin
                        state <= OVER;
                        cnt   <= '0;
                    end else if (!Pause) begin
                        state <= RUN;
                    end
                end
                OVER: begin
                    cnt <= '0;
                    if (Start) begin
                        state <= RUN;
                        lt    <= '0;
                        Level <= 2'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Running  = (state == RUN);
    assign GameOver = (state == OVER);

endmodule
